// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-ported register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;

  // INIT sweeps zeros through the array; READY is normal operation.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Address width for a given register count (minimum 1 bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-writeback flag per architectural register.
// Entry 0 is never busy; a reservation beats a same-cycle writeback clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [AW-1:0]            set_addr,
  input  logic [NWR-1:0]           clr_en,
  input  logic [NWR-1:0][AW-1:0]   clr_addr,
  output logic [DEPTH-1:0]         busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears first, then set, so set wins on an address collision.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (clr_en[i]) busy_d[clr_addr[i]] = 1'b0;
    end
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy-bit register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with zero-sweep init and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data (and a
// cleared busy flag) to reads of the same nonzero address.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr
);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   mem_d [DEPTH];
  logic [NWR-1:0]    wr_acc_c;
  logic              sb_set_c;
  logic [DEPTH-1:0]  busy_c;

  // Writes and reservations only take effect once the sweep is done.
  always_comb begin
    wr_acc_c = '0;
    for (int unsigned i = 0; i < NWR; i++) begin
      wr_acc_c[i] = (state_q == READY) && wr_en[i] && (wr_addr[i] != '0);
    end
    sb_set_c = (state_q == READY) && sb_set;
  end

  // Next-state: sweep cnt through 1..DEPTH-1, then settle in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = AW'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
    init_done_d = (state_d == READY);
  end

  // FSM, sweep counter and ready flag; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= AW'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Array update: sweep zero in INIT, otherwise higher write port wins.
  always_comb begin
    mem_d = mem_q;
    if (state_q == INIT) mem_d[cnt_q] = '0;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (wr_acc_c[i]) mem_d[wr_addr[i]] = wr_data[i];
    end
  end

  // Storage has no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set_c),
    .set_addr (sb_addr),
    .clr_en   (wr_acc_c),
    .clr_addr (wr_addr),
    .busy     (busy_c)
  );

  // Combinational read ports; entry 0 and the INIT phase read as zero.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      if ((state_q == READY) && (rd_addr[j] != '0)) begin
        rd_data[j] = mem_q[rd_addr[j]];
        rd_busy[j] = busy_c[rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned i = 0; i < NWR; i++) begin
          if (wr_acc_c[i] && (wr_addr[i] == rd_addr[j])) begin
            rd_data[j] = wr_data[i];
            rd_busy[j] = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural array model.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     init_done;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     sb_set;
  logic [AW-1:0]            sb_addr;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] ref_mem  [DEPTH];
  bit              ref_busy [DEPTH];
  bit              ref_ready;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN (XLEN), .DEPTH (DEPTH), .NRD (NRD), .NWR (NWR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read value: register contents, zero for x0 / before ready.
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (ref_ready && a != 0) begin
      v = ref_mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i] == a) v = wr_data[i];
`endif
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    if (ref_ready && a != 0) begin
      b = ref_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i] == a) b = 1'b0;
`endif
    end
    return b;
  endfunction

  task automatic check_ports(input string tag);
    for (int j = 0; j < NRD; j++) begin
      chk($sformatf("%s_data%0d_a%0d", tag, j, rd_addr[j]), rd_data[j], exp_data(rd_addr[j]));
      chk($sformatf("%s_busy%0d_a%0d", tag, j, rd_addr[j]), 32'(rd_busy[j]), 32'(exp_busy(rd_addr[j])));
    end
  endtask

  // One clock: update the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) ref_busy[a] = 0;
      ref_ready = 0;
    end else if (ref_ready) begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && wr_addr[i] != 0) begin
          ref_mem[wr_addr[i]]  = wr_data[i];
          ref_busy[wr_addr[i]] = 0;
        end
      end
      if (sb_set && sb_addr != 0) ref_busy[sb_addr] = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = '0;
    sb_set = 1'b0;
  endtask

  // Count edges from reset release until init_done; reads must be zero meanwhile.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
      chk({tag, "_initrd"}, rd_data[0] | rd_data[1], 32'h0);
      chk({tag, "_initbusy"}, 32'(rd_busy), 32'h0);
    end
    chk({tag, "_len"}, 32'(n), 32'd31);
    @(negedge clk);
    idle();
    ref_ready = 1;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(DEPTH - 1 - a);
      #1;
      chk({tag, "_zero"}, rd_data[0], 32'h0);
      check_ports(tag);
    end
  endtask

  initial begin
    ref_ready = 0;
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a]  = '0;
      ref_busy[a] = 0;
    end
    // Reset with write/reserve traffic that INIT must ignore.
    reset      = 1'b1;
    wr_en      = '1;
    wr_addr[0] = 5'd5;
    wr_addr[1] = 5'd9;
    wr_data[0] = 32'hFFFF_FFFF;
    wr_data[1] = 32'h5555_5555;
    sb_set     = 1'b1;
    sb_addr    = 5'd9;
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd9;
    @(posedge clk);
    #1;
    chk("reset_init_done", 32'(init_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_init("boot");
    chk("ready_init_done", 32'(init_done), 32'h1);
    read_all("boot");

    // x5 written, read on both ports next cycle.
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd2;
    tick(); idle();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    #1;
    chk("x5_p0", rd_data[0], 32'hDEADBEEF);
    chk("x5_p1", rd_data[1], 32'hDEADBEEF);

    // x0 is hardwired to zero.
    wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'h1234;
    tick(); idle();
    rd_addr[0] = 5'd0;
    #1;
    chk("x0_read", rd_data[0], 32'h0);

    // Same-address writes: port 1 wins.
    wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    tick(); idle();
    rd_addr[0] = 5'd7;
    #1;
    chk("x7_prio", rd_data[0], 32'h2);

    // Reserve and write x9 together: reservation wins; later write clears.
    sb_set = 1'b1; sb_addr = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
    tick(); idle();
    rd_addr[0] = 5'd9;
    #1;
    chk("x9_busy_set", 32'(rd_busy[0]), 32'h1);
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h77;
    rd_addr[0] = 5'd1;
    tick(); idle();
    rd_addr[0] = 5'd9;
    #1;
    chk("x9_busy_clr", 32'(rd_busy[0]), 32'h0);
    chk("x9_data", rd_data[0], 32'h77);

    // Reservation is not visible in the same cycle.
    sb_set = 1'b1; sb_addr = 5'd4; rd_addr[1] = 5'd4;
    #1;
    chk("x4_busy_same", 32'(rd_busy[1]), 32'h0);
    tick(); idle();
    #1;
    chk("x4_busy_next", 32'(rd_busy[1]), 32'h1);

    // Same-cycle write/read of x3.
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
    tick(); idle();
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hA5; rd_addr[0] = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x3_same_cycle", rd_data[0], 32'hA5);
`else
    chk("x3_same_cycle", rd_data[0], 32'h11);
`endif
    tick(); idle();
    #1;
    chk("x3_after", rd_data[0], 32'hA5);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en = NWR'($urandom_range(0, 3));
      for (int i = 0; i < NWR; i++) begin
        wr_addr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                 : AW'($urandom_range(0, 7));
        wr_data[i] = $urandom;
      end
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = AW'($urandom_range(0, 7));
      for (int j = 0; j < NRD; j++) rd_addr[j] = AW'($urandom_range(0, 7));
      #1;
      check_ports("rand");
      tick();
    end
    idle();

    // Reset in READY, then again mid-sweep at cnt=10; sweep restarts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_init_done", 32'(init_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_init("restart");
    read_all("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of architectural registers (power of two, >=2).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports (1..2).
REQ-005 SHALL have local constant AW = clog2(DEPTH).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port init_done  output  1  register array clear and block ready.
REQ-009 SHALL have port rd_addr  input  NRD x AW  read addresses.
REQ-010 SHALL have port rd_data  output  NRD x XLEN  read data, combinational.
REQ-011 SHALL have port rd_busy  output  NRD  scoreboard busy flag of each rd_addr.
REQ-012 SHALL have port wr_en  input  NWR  write strobes.
REQ-013 SHALL have port wr_addr  input  NWR x AW  write addresses.
REQ-014 SHALL have port wr_data  input  NWR x XLEN  write data.
REQ-015 SHALL have port sb_set  input  1  mark sb_addr busy (pending writeback).
REQ-016 SHALL have port sb_addr  input  AW  scoreboard reserve address.

Function
REQ-017 SHALL implement FSM {INIT, READY}; INIT writes zero to entry cnt each cycle, cnt counts 1..DEPTH-1, and the FSM moves to READY the cycle after cnt = DEPTH-1.
REQ-018 SHALL assert init_done only in READY; INIT lasts exactly DEPTH-1 cycles after reset deasserts.
REQ-019 SHALL, in INIT, ignore wr_en and sb_set, and drive rd_data = 0 and rd_busy = 0.
REQ-020 SHALL write wr_data[i] to wr_addr[i] on the rising edge when wr_en[i]=1 in READY.
REQ-021 SHALL hardwire entry 0: writes to address 0 are dropped, reads of address 0 return 0, rd_busy for address 0 is always 0.
REQ-022 SHALL give write port NWR-1 priority when two ports write the same address in one cycle.
REQ-023 SHALL return the stored array value on rd_data[j] with zero-cycle latency (combinational on rd_addr).
REQ-024 SHALL set busy[sb_addr] on an sb_set edge and clear busy[a] on any accepted write to a.
REQ-025 SHALL let set win when sb_set and a write target the same address in one cycle (busy stays 1).
REQ-026 SHALL drive rd_busy[j] = busy[rd_addr[j]] from registered state, with no same-cycle forwarding of sb_set.

Reset
REQ-027 SHALL, while reset=1, enter INIT, load cnt=1, clear all busy bits, and drive init_done=0.
REQ-028 SHALL abort any in-progress INIT or READY activity on reset and restart the sweep from cnt=1.
REQ-029 SHALL NOT rely on reset to clear the array directly; only the INIT sweep clears it (RAM-mappable).

Configuration
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to a read of the same nonzero address (priority per REQ-022), and also return rd_busy=0 for it.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return the old array value and old busy state in that case.

Structure
REQ-032 SHALL place the FSM state enum, the default XLEN/DEPTH constants, and the AW helper in shared package regfile_pkg.
REQ-033 SHALL put the busy-bit array and its set/clear priority in sub-module regfile_scoreboard; the array, FSM, and bypass stay in regfile_mp.

Verification
REQ-034 SHALL cover: reset 1 cycle, DEPTH=32 -> init_done rises exactly 31 cycles later, and all 32 reads return 0.
REQ-035 SHALL cover: write x5=0xDEADBEEF, then read x5 on both ports next cycle -> 0xDEADBEEF on both.
REQ-036 SHALL cover: write x0=0x1234 -> reading x0 returns 0.
REQ-037 SHALL cover: both ports write x7 (0x1, 0x2) in one cycle -> x7 reads 0x2.
REQ-038 SHALL cover: sb_set x9 and write x9 in the same cycle -> rd_busy=1; a later write to x9 -> rd_busy=0.
REQ-039 SHALL cover: a same-cycle write/read of x3=0xA5 -> 0xA5 with REGFILE_BYPASS_EN defined, the old value without it; and reset at cnt=10 -> init_done 31 cycles after release.
